uart_receiver: RTL and testbench

UART_RECEIVER -- requirements
Module: uart_receiver

---
 rtl/uart_receiver.sv | 191 +++++++++++++++++++
 tb/tb_uart_receiver.sv | 230 +++++++++++++++++++++++
 2 files changed

// File: rtl/uart_receiver.sv
// Oversampling UART receiver: start, MSB-first data, even parity, STOP_BITS stops.
// Each completed frame is pushed as one word with break/parity/frame qualifiers.
//
// state      | meaning
// IDLE       | line idle, waiting for synchronized Rx low
// START      | timing to start-bit mid-sample, rejects false starts
// DATA       | sampling DATA_BITS data bits, MSB first
// PARITY     | sampling the even-parity bit
// STOP       | sampling STOP_BITS stop bits, word issued at the last one
// BREAK_WAIT | break seen, holding until the line returns high
module uart_receiver #(
  parameter int SYSCLK_RATE = 100000000,
  parameter int BAUD_RATE   = 9600,
  parameter int DATA_BITS   = 8,
  parameter int STOP_BITS   = 2,
  parameter int OVERSAMPLE  = 16
) (
  input  logic                 Clk,
  input  logic                 Rst,
  input  logic                 Rx,
  input  logic                 Push_Ready,
  output logic [DATA_BITS-1:0] Rx_Data,
  output logic                 Rx_Valid,
  output logic [2:0]           Rx_Error,
  output logic                 Rx_Overrun,
  output logic                 Rx_Busy
);

  localparam int DIV_RAW = SYSCLK_RATE / (BAUD_RATE * OVERSAMPLE);
  localparam int DIV     = (DIV_RAW < 1) ? 1 : DIV_RAW;
  localparam int DIV_W   = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int OS_W    = (OVERSAMPLE > 1) ? $clog2(OVERSAMPLE) : 1;
  localparam int BIT_MAX = (DATA_BITS > STOP_BITS) ? DATA_BITS : STOP_BITS;
  localparam int BIT_W   = (BIT_MAX > 1) ? $clog2(BIT_MAX) : 1;

  localparam logic [DIV_W-1:0] DIV_LAST  = DIV_W'(DIV - 1);
  localparam logic [OS_W-1:0]  HALF_LAST = OS_W'(OVERSAMPLE / 2 - 1);
  localparam logic [OS_W-1:0]  FULL_LAST = OS_W'(OVERSAMPLE - 1);
  localparam logic [BIT_W-1:0] DATA_LAST = BIT_W'(DATA_BITS - 1);
  localparam logic [BIT_W-1:0] STOP_LAST = BIT_W'(STOP_BITS - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_START, S_DATA, S_PARITY, S_STOP, S_BREAK_WAIT
  } state_t;

  state_t               state_q, state_d;
  logic                 rx_meta_q, rx_meta_d;
  logic                 rx_sync_q, rx_sync_d;
  logic [DIV_W-1:0]     div_cnt_q, div_cnt_d;
  logic [OS_W-1:0]      samp_cnt_q, samp_cnt_d;
  logic [BIT_W-1:0]     bit_cnt_q, bit_cnt_d;
  logic [DATA_BITS-1:0] shift_q, shift_d;
  logic                 par_bit_q, par_bit_d;
  logic                 any_one_q, any_one_d;
  logic                 stop_zero_q, stop_zero_d;
  logic [DATA_BITS-1:0] data_q, data_d;
  logic [2:0]           err_q, err_d;
  logic                 valid_q, valid_d;
  logic                 ovr_q, ovr_d;

  logic tick, sample, brk, stop_zero_now, any_one_now;

  always_comb begin
    state_d       = state_q;
    rx_meta_d     = Rx;
    rx_sync_d     = rx_meta_q;
    div_cnt_d     = div_cnt_q;
    samp_cnt_d    = samp_cnt_q;
    bit_cnt_d     = bit_cnt_q;
    shift_d       = shift_q;
    par_bit_d     = par_bit_q;
    any_one_d     = any_one_q;
    stop_zero_d   = stop_zero_q;
    data_d        = data_q;
    err_d         = err_q;
    valid_d       = 1'b0;
    ovr_d         = 1'b0;
    stop_zero_now = stop_zero_q | ~rx_sync_q;
    any_one_now   = any_one_q | rx_sync_q;
    brk           = ~any_one_now;

    tick   = (state_q != S_IDLE) && (div_cnt_q == '0);
    sample = tick && (samp_cnt_q == '0);

    if (state_q != S_IDLE) begin
      div_cnt_d = tick ? DIV_LAST : div_cnt_q - 1'b1;
    end
    if (tick) begin
      samp_cnt_d = (samp_cnt_q == '0) ? FULL_LAST : samp_cnt_q - 1'b1;
    end

    case (state_q)
      S_IDLE: begin
        if (!rx_sync_q) begin
          state_d     = S_START;
          div_cnt_d   = DIV_LAST;
          samp_cnt_d  = HALF_LAST;
          any_one_d   = 1'b0;
          stop_zero_d = 1'b0;
        end
      end
      S_START: begin
        if (sample) begin
          if (rx_sync_q) begin
            state_d = S_IDLE;
          end else begin
            state_d   = S_DATA;
            bit_cnt_d = DATA_LAST;
          end
        end
      end
      S_DATA: begin
        if (sample) begin
          shift_d   = DATA_BITS'({shift_q, rx_sync_q});
          any_one_d = any_one_now;
          if (bit_cnt_q == '0) state_d = S_PARITY;
          else                 bit_cnt_d = bit_cnt_q - 1'b1;
        end
      end
      S_PARITY: begin
        if (sample) begin
          par_bit_d = rx_sync_q;
          any_one_d = any_one_now;
          state_d   = S_STOP;
          bit_cnt_d = STOP_LAST;
        end
      end
      S_STOP: begin
        if (sample) begin
          any_one_d   = any_one_now;
          stop_zero_d = stop_zero_now;
          if (bit_cnt_q == '0) begin
            // Break wins over parity and framing: an all-zero frame says nothing about either.
            valid_d = 1'b1;
            ovr_d   = ~Push_Ready;
            data_d  = shift_q;
            err_d   = {~brk & stop_zero_now, ~brk & (par_bit_q ^ (^shift_q)), brk};
            state_d = brk ? S_BREAK_WAIT : S_IDLE;
          end else begin
            bit_cnt_d = bit_cnt_q - 1'b1;
          end
        end
      end
      S_BREAK_WAIT: begin
        if (rx_sync_q) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      state_q     <= S_IDLE;
      rx_meta_q   <= 1'b1;
      rx_sync_q   <= 1'b1;
      div_cnt_q   <= '0;
      samp_cnt_q  <= '0;
      bit_cnt_q   <= '0;
      shift_q     <= '0;
      par_bit_q   <= 1'b0;
      any_one_q   <= 1'b0;
      stop_zero_q <= 1'b0;
      data_q      <= '0;
      err_q       <= '0;
      valid_q     <= 1'b0;
      ovr_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      rx_meta_q   <= rx_meta_d;
      rx_sync_q   <= rx_sync_d;
      div_cnt_q   <= div_cnt_d;
      samp_cnt_q  <= samp_cnt_d;
      bit_cnt_q   <= bit_cnt_d;
      shift_q     <= shift_d;
      par_bit_q   <= par_bit_d;
      any_one_q   <= any_one_d;
      stop_zero_q <= stop_zero_d;
      data_q      <= data_d;
      err_q       <= err_d;
      valid_q     <= valid_d;
      ovr_q       <= ovr_d;
    end
  end

  assign Rx_Data    = data_q;
  assign Rx_Error   = err_q;
  assign Rx_Valid   = valid_q;
  assign Rx_Overrun = ovr_q;
  assign Rx_Busy    = (state_q != S_IDLE);

endmodule

// File: tb/tb_uart_receiver.sv
// Bench for uart_receiver at 16 clocks per bit: directed frame table, randomized
// frames against a frame-level reference model, and break/false-start/reset sequences.
module tb_uart_receiver;

  localparam int BIT_CLKS = 16;

  logic       Clk = 1'b0;
  logic       Rst = 1'b1;
  logic       Rx = 1'b1;
  logic       Push_Ready = 1'b1;
  logic [7:0] Rx_Data;
  logic       Rx_Valid;
  logic [2:0] Rx_Error;
  logic       Rx_Overrun;
  logic       Rx_Busy;

  uart_receiver #(
    .SYSCLK_RATE(1600), .BAUD_RATE(100), .DATA_BITS(8), .STOP_BITS(2), .OVERSAMPLE(16)
  ) dut (
    .Clk(Clk), .Rst(Rst), .Rx(Rx), .Push_Ready(Push_Ready),
    .Rx_Data(Rx_Data), .Rx_Valid(Rx_Valid), .Rx_Error(Rx_Error),
    .Rx_Overrun(Rx_Overrun), .Rx_Busy(Rx_Busy)
  );

  always #5 Clk = ~Clk;

  int vectors = 0;
  int miscompares = 0;

  // Output monitor, sampled on the falling edge.
  int         valid_cnt = 0;
  int         bad_pulse = 0;
  logic       cap_done = 1'b0;
  logic       prev_valid = 1'b0;
  logic [7:0] cap_data = '0;
  logic [2:0] cap_err = '0;
  logic       cap_ovr = 1'b0;

  always @(negedge Clk) begin
    if (Rx_Valid === 1'b1) begin
      valid_cnt++;
      if (prev_valid) bad_pulse++;
      if (!cap_done) begin
        cap_data = Rx_Data;
        cap_err  = Rx_Error;
        cap_ovr  = Rx_Overrun;
        cap_done = 1'b1;
      end
    end
    if (Rx_Overrun === 1'b1 && Rx_Valid !== 1'b1) bad_pulse++;
    prev_valid = (Rx_Valid === 1'b1);
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  typedef struct {
    logic [7:0] data;
    logic       par_flip;
    logic [1:0] stops;      // [0] first stop bit, [1] second
    logic       push_ready;
    logic [7:0] exp_data;
    logic [2:0] exp_err;
    logic       exp_ovr;
  } vec_t;

  // Frame-level expectation from the bits put on the line.
  task automatic model(input logic [7:0] data, input logic par, input logic [1:0] stops,
                       input logic pr, output logic [7:0] ed, output logic [2:0] ee,
                       output logic eo);
    logic [10:0] line_bits;
    logic        brk;
    line_bits = {data, par, stops};
    brk = (line_bits == 11'd0);
    ed = data;
    ee[0] = brk;
    ee[1] = !brk && (par != (^data));
    ee[2] = !brk && (stops != 2'b11);
    eo = !pr;
  endtask

  task automatic drive_bit(input logic b);
    Rx = b;
    repeat (BIT_CLKS) @(posedge Clk);
    #1;
  endtask

  task automatic run_frame(input string tag, input logic [7:0] data, input logic par_flip,
                           input logic [1:0] stops, input logic pr, input logic [7:0] ed,
                           input logic [2:0] ee, input logic eo);
    logic par;
    par = (^data) ^ par_flip;
    valid_cnt = 0;
    cap_done = 1'b0;
    Push_Ready = pr;
    drive_bit(1'b0);
    for (int i = 7; i >= 0; i--) drive_bit(data[i]);
    drive_bit(par);
    drive_bit(stops[0]);
    drive_bit(stops[1]);
    Rx = 1'b1;
    repeat (40) @(posedge Clk);
    #1;
    check({tag, " valid count"}, valid_cnt, 1);
    check({tag, " data"}, cap_data, ed);
    check({tag, " error"}, cap_err, ee);
    check({tag, " overrun"}, cap_ovr, eo);
    // A low final stop leaves the line low after the frame; clear the resulting false start.
    if (!stops[1]) begin
      Rst = 1'b1;
      repeat (2) @(posedge Clk);
      #1 Rst = 1'b0;
      repeat (4) @(posedge Clk);
      #1;
    end
    Push_Ready = 1'b1;
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, " Rx_Data"}, Rx_Data, 0);
    check({tag, " Rx_Error"}, Rx_Error, 0);
    check({tag, " Rx_Valid"}, Rx_Valid, 0);
    check({tag, " Rx_Overrun"}, Rx_Overrun, 0);
    check({tag, " Rx_Busy"}, Rx_Busy, 0);
  endtask

  vec_t tbl[6];

  initial begin
    logic [7:0] d;
    logic       pf;
    logic [1:0] st;
    logic       pr;
    logic [7:0] ed;
    logic [2:0] ee;
    logic       eo;

    tbl[0] = '{8'hA5, 1'b0, 2'b11, 1'b1, 8'hA5, 3'b000, 1'b0};
    tbl[1] = '{8'hAA, 1'b1, 2'b11, 1'b1, 8'hAA, 3'b010, 1'b0};
    tbl[2] = '{8'hAA, 1'b0, 2'b00, 1'b1, 8'hAA, 3'b100, 1'b0};
    tbl[3] = '{8'h3C, 1'b0, 2'b11, 1'b0, 8'h3C, 3'b000, 1'b1};
    tbl[4] = '{8'hF0, 1'b1, 2'b01, 1'b1, 8'hF0, 3'b110, 1'b0};
    tbl[5] = '{8'h00, 1'b0, 2'b00, 1'b1, 8'h00, 3'b001, 1'b0};

    repeat (3) @(posedge Clk);
    #1;
    check_reset_outputs("reset");
    Rst = 1'b0;
    repeat (4) @(posedge Clk);
    #1;

    for (int i = 0; i < 6; i++) begin
      run_frame($sformatf("table%0d", i), tbl[i].data, tbl[i].par_flip, tbl[i].stops,
                tbl[i].push_ready, tbl[i].exp_data, tbl[i].exp_err, tbl[i].exp_ovr);
      if (i == 2) check("frame err then idle busy", Rx_Busy, 0);
    end

    // Long break: 12 bit times low.
    valid_cnt = 0;
    cap_done = 1'b0;
    Rx = 1'b0;
    repeat (12 * BIT_CLKS) @(posedge Clk);
    #1;
    check("break valid count", valid_cnt, 1);
    check("break error", cap_err, 3'b001);
    check("break data", cap_data, 8'h00);
    check("break busy while low", Rx_Busy, 1);
    Rx = 1'b1;
    repeat (6) @(posedge Clk);
    #1;
    check("break busy after high", Rx_Busy, 0);
    check("break no extra valid", valid_cnt, 1);

    // False start: 4 clocks low.
    valid_cnt = 0;
    Rx = 1'b0;
    repeat (4) @(posedge Clk);
    #1 Rx = 1'b1;
    repeat (10) @(posedge Clk);
    #1;
    check("false start busy", Rx_Busy, 0);
    repeat (200) @(posedge Clk);
    #1;
    check("false start no valid", valid_cnt, 0);

    // Randomized frames against the model.
    for (int n = 0; n < 20; n++) begin
      d  = 8'($urandom);
      pf = ($urandom_range(3) == 0);
      st = ($urandom_range(3) == 0) ? 2'($urandom_range(2)) : 2'b11;
      pr = ($urandom_range(3) != 0);
      if ($urandom_range(7) == 0) begin
        d = 8'h00; pf = 1'b0; st = 2'b00;
      end
      model(d, (^d) ^ pf, st, pr, ed, ee, eo);
      run_frame($sformatf("rand%0d", n), d, pf, st, pr, ed, ee, eo);
      repeat ($urandom_range(20)) @(posedge Clk);
      #1;
    end

    // Reset in the middle of a frame.
    valid_cnt = 0;
    drive_bit(1'b0);
    drive_bit(1'b1);
    drive_bit(1'b0);
    drive_bit(1'b1);
    check("midframe busy before reset", Rx_Busy, 1);
    #3 Rst = 1'b1;
    #1;
    check_reset_outputs("midframe reset");
    Rx = 1'b1;
    @(posedge Clk);
    #1 Rst = 1'b0;
    repeat (250) @(posedge Clk);
    #1;
    check("midframe no valid", valid_cnt, 0);
    check("midframe busy after", Rx_Busy, 0);

    check("valid/overrun pulse shape", bad_pulse, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
